period_classifier: RTL and testbench

Multi-channel period classifier for the signal-distinguishing front end. It counts `clk` cycles between successive rising edges on each comparator input `cmp[i]` and bins each measured period into one of four one-hot classes. At every `set` window strobe it publishes one class code per channel. It is the parametrised successor of the single-channel distinguish counter and adds three things that block lacks: a configurable channel count, an explicit no-signal report, and overflow reporting.

---
 rtl/period_classifier.sv | 171 +++++++++++++++++
 tb/tb_period_classifier.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/period_classifier.sv
// Multi-channel period classifier: measures clk cycles between cmp rising edges and
// publishes a one-hot period class per channel at each set strobe. Option: PC_HYST_EN.
module period_classifier #(
    parameter int CH  = 4,
    parameter int CW  = 16,
    parameter int TH0 = 200,
    parameter int TH1 = 500,
    parameter int TH2 = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   cmp,
    input  logic            set,
    output logic [4*CH-1:0] sel,
    output logic            sel_vld,
    output logic [CH-1:0]   ovf
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] TH0_C   = CW'(TH0);
    localparam logic [CW-1:0] TH1_C   = CW'(TH1);
    localparam logic [CW-1:0] TH2_C   = CW'(TH2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        MEAS  = 2'd2
    } state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    function automatic logic [3:0] classify(input logic [CW-1:0] m);
        if (m < TH0_C)
            return 4'b0001;
        else if (m < TH1_C)
            return 4'b0010;
        else if (m < TH2_C)
            return 4'b0100;
        return 4'b1000;
    endfunction

    logic [CH-1:0]   sync_p0, sync_p1, sync_p2, edge_p3;
    state_t          state     [CH];
    state_t          state_nxt [CH];
    logic [CH-1:0]   latch;
    logic [CW-1:0]   cnt       [CH];
    logic [CW-1:0]   cnt_nxt   [CH];
    logic [CW-1:0]   meas      [CH];
    logic [CH-1:0]   hit, hit_nxt, sat, sat_nxt;
    logic [3:0]      cls       [CH];
    logic [4*CH-1:0] sel_nxt;
    logic            set_d, set_rise;
`ifdef PC_HYST_EN
    logic [3:0]      cand      [CH];
`endif

    assign set_rise = set & ~set_d;

    // Stages p0/p1: synchronizer; p2/p3: rising-edge detect, registered
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            sync_p2 <= '0;
            edge_p3 <= '0;
        end else begin
            sync_p0 <= cmp;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            edge_p3 <= sync_p1 & ~sync_p2;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (rst)
                state[i] <= IDLE;
            else
                state[i] <= state_nxt[i];
        end
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            state_nxt[i] = state[i];
            if (edge_p3[i]) begin
                case (state[i])
                    IDLE:    state_nxt[i] = ARMED;
                    ARMED:   state_nxt[i] = MEAS;
                    default: state_nxt[i] = MEAS;
                endcase
            end
        end
    end

    always_comb begin
        latch = '0;
        for (int i = 0; i < CH; i++)
            latch[i] = edge_p3[i] && (state[i] != IDLE);
    end

    // An edge coinciding with window close belongs to the new window
    always_comb begin
        hit_nxt = '0;
        sat_nxt = '0;
        for (int i = 0; i < CH; i++) begin
            cnt_nxt[i] = edge_p3[i] ? CW'(1) : sat_inc(cnt[i]);
            hit_nxt[i] = (hit[i] & ~set_rise) | latch[i];
            sat_nxt[i] = (sat[i] & ~set_rise) | (cnt_nxt[i] == CNT_MAX);
            cls[i]     = hit[i] ? classify(meas[i]) : 4'b0000;
        end
    end

    always_comb begin
        sel_nxt = sel;
        for (int i = 0; i < CH; i++) begin
`ifdef PC_HYST_EN
            if (cls[i] == 4'b0000 || cls[i] == cand[i])
                sel_nxt[4*i +: 4] = cls[i];
`else
            sel_nxt[4*i +: 4] = cls[i];
`endif
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (latch[i])
                meas[i] <= cnt[i];
        end
    end

    // Window close: publish classes and overflow, restart sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++)
                cnt[i] <= '0;
            hit     <= '0;
            sat     <= '0;
            set_d   <= 1'b0;
            sel     <= '0;
            sel_vld <= 1'b0;
            ovf     <= '0;
        end else begin
            for (int i = 0; i < CH; i++)
                cnt[i] <= cnt_nxt[i];
            hit     <= hit_nxt;
            sat     <= sat_nxt;
            set_d   <= set;
            sel_vld <= set_rise;
            if (set_rise) begin
                sel <= sel_nxt;
                ovf <= sat;
            end
        end
    end

`ifdef PC_HYST_EN
    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (rst)
                cand[i] <= 4'b0000;
            else if (set_rise)
                cand[i] <= cls[i];
        end
    end
`endif

endmodule

// File: tb/tb_period_classifier.sv
// Bench for period_classifier: edge-time model per channel plus literal window checks.
`timescale 1ns/1ps
module tb_period_classifier;

    localparam int CH    = 4;
    localparam int CW    = 12;
    localparam int MAXV  = (1 << CW) - 1;
    localparam int TEND  = 33000;
    localparam int NSHOT = 18;
    localparam int SHOTS [NSHOT] = '{21597, 21897, 22497, 24900, 25100, 25600,
                                      26600, 26900, 27600, 28300, 28600, 28900,
                                      29600, 30300, 30600, 31300, 31600, 32300};
`ifdef PC_HYST_EN
    localparam bit HY = 1'b1;
`else
    localparam bit HY = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            set;
    logic [CH-1:0]   cmp;
    logic [4*CH-1:0] sel;
    logic            sel_vld;
    logic [CH-1:0]   ovf;

    period_classifier #(
        .CH(CH), .CW(CW), .TH0(200), .TH1(500), .TH2(1000)
    ) dut (
        .clk(clk), .rst(rst), .cmp(cmp), .set(set),
        .sel(sel), .sel_vld(sel_vld), .ovf(ovf)
    );

    always #500 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int t;
    int rbase, ws;
    int edges [CH][$];
    logic [CH-1:0]   prev_cmp;
    logic            prev_set;
    logic [4*CH-1:0] sel_exp;
    logic [CH-1:0]   ovf_exp;
    logic            vld_exp;
    logic [3:0]      cand [CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, t, act, exp);
        end
    endtask

    // ---------------- stimulus schedule (values sampled at posedge number tt) ----------------
    function automatic bit pulse(input int tt, input int s, input int e, input int per);
        return (tt >= s) && (tt < e) && (((tt - s) % per) < 2);
    endfunction

    function automatic bit shot(input int tt);
        for (int k = 0; k < NSHOT; k++)
            if (tt == SHOTS[k] || tt == SHOTS[k] + 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit rst_at(input int tt);
        return (tt >= 1 && tt <= 3) || (tt >= 25000 && tt <= 25002);
    endfunction

    function automatic logic [CH-1:0] cmp_at(input int tt);
        logic [CH-1:0] v;
        if (tt >= 1 && tt <= 3) begin
            v = (tt % 2 == 1) ? {CH{1'b1}} : {CH{1'b0}};
        end else begin
            v[0] = pulse(tt, 400, 3600, 300) | pulse(tt, 3600, 8000, 150) | shot(tt);
            v[1] = 1'b0;
            v[2] = pulse(tt, 3600, 8000, 700) | pulse(tt, 8000, 21000, 5000);
            v[3] = pulse(tt, 3600, 8000, 1200);
        end
        return v;
    endfunction

    function automatic bit set_at(input int tt);
        int hold;
        hold = (tt >= 10000 && tt < 20000) ? 40 : 3;
        return !rst_at(tt) && ((tt % 1000) >= 500) && ((tt % 1000) < 500 + hold);
    endfunction

    // ---------------- behavioural model ----------------
    function automatic int cnt_at(input int ch, input int p);
        int last, v;
        last = -1;
        for (int k = 0; k < edges[ch].size(); k++)
            if (edges[ch][k] <= p) last = edges[ch][k];
        v = (last < 0) ? (p - rbase) : (p - last + 1);
        return (v > MAXV) ? MAXV : v;
    endfunction

    function automatic logic [3:0] class_of(input int v);
        if (v < 200) return 4'b0001;
        if (v < 500) return 4'b0010;
        if (v < 1000) return 4'b0100;
        return 4'b1000;
    endfunction

    task automatic close_window(input int m);
        bit hitf, satf;
        int measv, e, d;
        logic [3:0] c;
        for (int ch = 0; ch < CH; ch++) begin
            hitf = 1'b0;
            measv = 0;
            for (int k = 1; k < edges[ch].size(); k++) begin
                e = edges[ch][k];
                if (e >= ws && e <= m - 1) begin
                    hitf = 1'b1;
                    d = e - edges[ch][k-1];
                    measv = (d > MAXV) ? MAXV : d;
                end
            end
            satf = (cnt_at(ch, m - 1) == MAXV);
            for (int k = 0; k < edges[ch].size(); k++) begin
                e = edges[ch][k];
                if (e >= ws + 1 && e <= m - 1 && cnt_at(ch, e - 1) == MAXV) satf = 1'b1;
            end
            c = hitf ? class_of(measv) : 4'b0000;
            if (!HY || c == 4'b0000 || c == cand[ch]) sel_exp[4*ch +: 4] = c;
            cand[ch] = c;
            ovf_exp[ch] = satf;
        end
        ws = m;
        vld_exp = 1'b1;
    endtask

    task automatic model_step();
        if (rst) begin
            for (int ch = 0; ch < CH; ch++) begin
                edges[ch].delete();
                cand[ch] = 4'b0000;
            end
            rbase = t;
            ws = t + 1;
            sel_exp = '0;
            ovf_exp = '0;
            vld_exp = 1'b0;
            prev_cmp = '0;
            prev_set = 1'b0;
        end else begin
            for (int ch = 0; ch < CH; ch++)
                if (cmp[ch] && !prev_cmp[ch]) edges[ch].push_back(t + 3);
            prev_cmp = cmp;
            vld_exp = 1'b0;
            if (set && !prev_set) close_window(t);
            prev_set = set;
        end
    endtask

    // ---------------- hand-computed expectations ----------------
    task automatic lit_checks();
        case (t)
            1, 2, 3: begin
                chk("reset_sel", 32'(sel), 32'(0));
                chk("reset_vld", 32'(sel_vld), 32'(0));
                chk("reset_ovf", 32'(ovf), 32'(0));
            end
            500: begin
                chk("arm_only_sel0", 32'(sel[3:0]), 32'(4'b0000));
                chk("vld_pulse", 32'(sel_vld), 32'(1));
            end
            501:   chk("vld_single", 32'(sel_vld), 32'(0));
            1500: begin
                chk("class1_w2", 32'(sel[3:0]), 32'(HY ? 4'b0000 : 4'b0010));
                chk("no_ovf0", 32'(ovf[0]), 32'(0));
            end
            2500:  chk("class1_w3", 32'(sel[3:0]), 32'(4'b0010));
            4500:  chk("ovf_silent_ch1", 32'(ovf[1]), 32'(1));
            6500:  chk("all_classes", 32'(sel), 32'(16'h8401));
            10501: chk("held_set_vld", 32'(sel_vld), 32'(0));
            12500: begin
                chk("ovf_noedge_sel2", 32'(sel[11:8]), 32'(4'b0000));
                chk("ovf_noedge_ovf2", 32'(ovf[2]), 32'(1));
            end
            13500: begin
                chk("ovf_edge_sel2", 32'(sel[11:8]), 32'(HY ? 4'b0000 : 4'b1000));
                chk("ovf_edge_ovf2", 32'(ovf[2]), 32'(1));
            end
            22500: chk("coinc_prev_meas", 32'(sel[3:0]), 32'(HY ? 4'b0000 : 4'b0010));
            23500: chk("coinc_next_hit", 32'(sel[3:0]), 32'(HY ? 4'b0000 : 4'b0100));
            24500: chk("no_signal", 32'(sel[3:0]), 32'(4'b0000));
            25001: chk("midrst_sel", 32'(sel), 32'(0));
            25500: begin
                chk("rearm_sel0", 32'(sel[3:0]), 32'(4'b0000));
                chk("rearm_ovf1", 32'(ovf[1]), 32'(0));
            end
            26500: chk("post_rst_class", 32'(sel[3:0]), 32'(HY ? 4'b0000 : 4'b0100));
            29500: chk("alt_300", 32'(sel[3:0]), 32'(HY ? 4'b0000 : 4'b0010));
            30500: chk("first_700", 32'(sel[3:0]), 32'(HY ? 4'b0000 : 4'b0100));
            31500: chk("second_700", 32'(sel[3:0]), 32'(4'b0100));
            default: ;
        endcase
    endtask

    initial begin
        t = 0;
        rbase = 0;
        ws = 1;
        prev_cmp = '0;
        prev_set = 1'b0;
        sel_exp = '0;
        ovf_exp = '0;
        vld_exp = 1'b0;
        for (int ch = 0; ch < CH; ch++) cand[ch] = 4'b0000;
        rst = rst_at(1);
        set = set_at(1);
        cmp = cmp_at(1);
        while (t < TEND) begin
            @(posedge clk);
            t++;
            #1;
            model_step();
            lit_checks();
            rst = rst_at(t + 1);
            set = set_at(t + 1);
            cmp = cmp_at(t + 1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (t >= 1) begin
                chk("sel", 32'(sel), 32'(sel_exp));
                chk("ovf", 32'(ovf), 32'(ovf_exp));
                chk("sel_vld", 32'(sel_vld), 32'(vld_exp));
            end
        end
    end

endmodule
